// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder_if
//  Description : Operand/result handshake bundle for pipelined_adder.
//                The master side supplies operands and result back-pressure;
//                the slave side (the adder) returns in_ready and the result.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_output_bit;
  logic             overflow;

  modport master (
    output in_valid, x, y, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_output_bit, overflow
  );

  modport slave (
    input  in_valid, x, y, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_output_bit, overflow
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder
//  Description : Streaming adder/subtractor, x + (sub ? ~y : y) + carry_in.
//                One CHUNK-bit slice is added per pipeline stage and the
//                carry ripples between stages through registers. Signed
//                overflow and carry-out are reported with each result.
//                Valid/ready on both sides with a single global advance
//                enable: the whole pipe moves or the whole pipe holds.
//  Revision    : 1.0  initial release
// ============================================================================
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pipelined_adder_if.slave  bus
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_param_check
    $error("pipelined_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  // Per-stage state. r_acc carries the finished low sum bits with the
  // not-yet-added x bits above them, so each stage only overwrites its slice.
  // r_y holds y_eff; its top bit doubles as the y_eff sign for overflow.
  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_acc   [STAGES];
  logic [WIDTH-1:0] r_y     [STAGES];
  logic             r_c     [STAGES];
  logic             r_sx    [STAGES];

  logic             w_en;
  logic [WIDTH-1:0] w_y_eff;
  logic [CHUNK:0]   w_slice [STAGES];

  // The pipe advances whenever the output register is empty or being taken.
  assign w_en         = bus.out_ready | ~r_valid[LAST];
  assign bus.in_ready = w_en;
  assign w_y_eff      = bus.sub ? ~bus.y : bus.y;

  // Slice 0 adds straight from the inputs with the external carry.
  assign w_slice[0] = {1'b0, bus.x[CHUNK-1:0]} + {1'b0, w_y_eff[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, bus.carry_in};

  for (genvar k = 1; k < STAGES; k++) begin : g_slice
    // Slice k adds the operands carried by stage k-1 and its stored carry.
    assign w_slice[k] = {1'b0, r_acc[k-1][k*CHUNK +: CHUNK]}
                      + {1'b0, r_y[k-1][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, r_c[k-1]};
  end

  // Pipeline registers: clear on reset, shift every stage together on w_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_acc[k]   <= '0;
        r_y[k]     <= '0;
        r_c[k]     <= 1'b0;
        r_sx[k]    <= 1'b0;
      end
    end else if (w_en) begin
      r_valid[0] <= bus.in_valid;
      // Bubbles load zeros so stored carries and flags never pick up
      // unknown operand values presented without in_valid.
      if (bus.in_valid) begin
        r_acc[0]              <= bus.x;
        r_acc[0][CHUNK-1:0]   <= w_slice[0][CHUNK-1:0];
        r_y[0]                <= w_y_eff;
        r_c[0]                <= w_slice[0][CHUNK];
        r_sx[0]               <= bus.x[WIDTH-1];
      end else begin
        r_acc[0] <= '0;
        r_y[0]   <= '0;
        r_c[0]   <= 1'b0;
        r_sx[0]  <= 1'b0;
      end
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k]                  <= r_valid[k-1];
        r_acc[k]                    <= r_acc[k-1];
        r_acc[k][k*CHUNK +: CHUNK]  <= w_slice[k][CHUNK-1:0];
        r_y[k]                      <= r_y[k-1];
        r_c[k]                      <= w_slice[k][CHUNK];
        r_sx[k]                     <= r_sx[k-1];
      end
    end
  end

  assign bus.out_valid        = r_valid[LAST];
  assign bus.sum              = r_acc[LAST];
  assign bus.carry_output_bit = r_c[LAST];
  assign bus.overflow         = (r_sx[LAST] == r_y[LAST][WIDTH-1])
                              & (r_acc[LAST][WIDTH-1] != r_sx[LAST]);

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_adder
//  Description : Self-checking bench for pipelined_adder (32/8 and 8/8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        c;
    logic        ov;
  } exp_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic        sb;
    logic [31:0] sum;
    logic        c;
    logic        ov;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  exp_t q [$];

  pipelined_adder_if #(.WIDTH(32)) bus  ();
  pipelined_adder_if #(.WIDTH(8))  nbus ();

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipelined_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (nbus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_vec += 5;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    if (bus.sum !== 32'h0) begin n_err++; $display("FAIL reset_sum: got %h, required 0", bus.sum); end
    if (bus.carry_output_bit !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b, required 0", bus.carry_output_bit); end
    if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b, required 0", bus.overflow); end
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
  endtask

  task automatic test_latency();
    int n;
    bus.out_ready = 1'b1;
    bus.x = 32'h0000_00FF; bus.y = 32'h1; bus.carry_in = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      n++;
    end while (!bus.out_valid && n < 20);
    n_vec += 2;
    if (n != 4) begin n_err++; $display("FAIL latency: got %0d cycles, required 4", n); end
    if ({bus.sum, bus.carry_output_bit, bus.overflow} !== {32'h0000_0100, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL case1_result: got sum=%h c=%b ov=%b, required sum=00000100 c=0 ov=0",
               bus.sum, bus.carry_output_bit, bus.overflow);
    end
  endtask

  task automatic test_flags();
    vec_t tv [7];
    exp_t e;
    int   sent, got, cyc;
    tv[0] = {32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tv[1] = {32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tv[2] = {32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tv[3] = {32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tv[4] = {32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    tv[5] = {32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    tv[6] = {32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    sent = 0; got = 0; cyc = 0;
    bus.out_ready = 1'b1;
    while (got < 7 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL flags_extra: got sum=%h, required no output", bus.sum);
        end else begin
          e = q.pop_front();
          if ({bus.sum, bus.carry_output_bit, bus.overflow} !== {e.sum, e.c, e.ov}) begin
            n_err++;
            $display("FAIL flags_%0d: got sum=%h c=%b ov=%b, required sum=%h c=%b ov=%b",
                     got, bus.sum, bus.carry_output_bit, bus.overflow, e.sum, e.c, e.ov);
          end
          got++;
        end
      end
      if (sent < 7) begin
        bus.x = tv[sent].x; bus.y = tv[sent].y;
        bus.carry_in = tv[sent].cin; bus.sub = tv[sent].sb;
        bus.in_valid = 1'b1;
        if (bus.in_ready) begin
          q.push_back({tv[sent].sum, tv[sent].c, tv[sent].ov});
          sent++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (got != 7) begin n_err++; $display("FAIL flags_timeout: got %0d results, required 7", got); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   sent, got, cyc, stall_left;
    bit   stall_done;
    sent = 0; got = 0; cyc = 0; stall_left = 0; stall_done = 1'b0;
    q.delete();
    bus.carry_in = 1'b0; bus.sub = 1'b0; bus.y = 32'd100;
    while (got < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid && !stall_done) begin
        stall_left = 5;
        stall_done = 1'b1;
      end
      bus.out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        n_vec += 2;
        if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b, required 0", bus.in_ready); end
        if (bus.sum !== 32'd100 || bus.out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL stall_hold: got sum=%0d valid=%b, required sum=100 valid=1", bus.sum, bus.out_valid);
        end
        stall_left--;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_extra: got sum=%0d, required no output", bus.sum);
        end else begin
          e = q.pop_front();
          if ({bus.sum, bus.carry_output_bit, bus.overflow} !== {e.sum, e.c, e.ov}) begin
            n_err++;
            $display("FAIL b2b_%0d: got sum=%0d c=%b ov=%b, required sum=%0d c=%b ov=%b",
                     got, bus.sum, bus.carry_output_bit, bus.overflow, e.sum, e.c, e.ov);
          end
          got++;
        end
      end
      if (sent < 10) begin
        bus.x = 32'(sent);
        bus.in_valid = 1'b1;
        if (bus.in_ready) begin
          q.push_back({32'(sent + 100), 1'b0, 1'b0});
          sent++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n_vec++;
    if (got != 10) begin n_err++; $display("FAIL b2b_timeout: got %0d results, required 10", got); end
    repeat (6) @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_duplicate: got out_valid=%b, required 0", bus.out_valid); end
  endtask

  task automatic test_reset_flight();
    bit seen;
    bus.out_ready = 1'b1;
    bus.carry_in = 1'b0; bus.sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.x = 32'hAAAA_0000 + 32'(i); bus.y = 32'h0000_1111;
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec += 3;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flight_out_valid: got %b, required 0", bus.out_valid); end
    if (bus.sum !== 32'h0) begin n_err++; $display("FAIL flight_sum: got %h, required 0", bus.sum); end
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flight_in_ready: got %b, required 1", bus.in_ready); end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL flight_discard: got discarded result=%b, required 0", seen); end
  endtask

  task automatic test_narrow();
    logic [7:0] xs [2];
    logic [7:0] ys [2];
    logic       cs [2];
    int         n;
    xs[0] = 8'hFF; ys[0] = 8'h01; cs[0] = 1'b0;
    xs[1] = 8'hFF; ys[1] = 8'h00; cs[1] = 1'b1;
    nbus.out_ready = 1'b1;
    nbus.sub = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nbus.x = xs[i]; nbus.y = ys[i]; nbus.carry_in = cs[i];
      nbus.in_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        nbus.in_valid = 1'b0;
        n++;
      end while (!nbus.out_valid && n < 10);
      n_vec += 2;
      if (n != 1) begin n_err++; $display("FAIL narrow_latency_%0d: got %0d cycles, required 1", i, n); end
      if ({nbus.sum, nbus.carry_output_bit, nbus.overflow} !== {8'h00, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL narrow_result_%0d: got sum=%h c=%b ov=%b, required sum=00 c=1 ov=0",
                 i, nbus.sum, nbus.carry_output_bit, nbus.overflow);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.carry_in = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    nbus.in_valid = 1'b0; nbus.x = '0; nbus.y = '0; nbus.carry_in = 1'b0; nbus.sub = 1'b0;
    nbus.out_ready = 1'b1;
    test_reset();
    test_latency();
    test_flags();
    test_back_to_back();
    test_reset_flight();
    test_narrow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
